// File: rtl/fifo_rd_drain.sv
// Read-side drain for async_fifo: issues rd_en, captures rd_data a cycle later, and streams words out on valid/ready.
// Optional build macro FIFO_RD_DRAIN_STATS_EN adds a 16-bit wrapping pop counter output (pop_count).
module fifo_rd_drain #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy
`ifdef FIFO_RD_DRAIN_STATS_EN
    ,
    output logic [15:0]           pop_count
`endif
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CNT_W = OCC_W + 1;

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];

    logic [OCC_W-1:0]      occ_q,      occ_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic                  inflight_q, inflight_d;
    logic                  m_valid_q,  m_valid_d;
    logic                  busy_q,     busy_d;
    logic [DATA_WIDTH-1:0] m_data_q,   m_data_d;

    logic                  pop_c;
    logic                  capture_c;
    logic                  rd_en_c;
    logic [CNT_W-1:0]      slots_c;

    // Issue logic: a read is allowed only if its word is guaranteed a queue slot after this cycle's pop.
    always_comb begin
        pop_c     = m_valid_q & m_ready;
        capture_c = inflight_q;
        slots_c   = CNT_W'(occ_q) + CNT_W'(inflight_q) - CNT_W'(pop_c);
        rd_en_c   = ~rst & ~flush & enable & ~fifo_empty
                    & (slots_c < CNT_W'(BUF_DEPTH));
    end

    assign fifo_rd_en = rd_en_c;

    // Next-state for queue bookkeeping and the registered output stage.
    always_comb begin
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = rd_en_c;
        m_data_d   = m_data_q;

        if (capture_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        occ_d = occ_q + OCC_W'(capture_c) - OCC_W'(pop_c);

        // Head after this edge: the arriving word if the queue drains to it, else the stored entry.
        if (capture_c && (occ_q == OCC_W'(pop_c))) begin
            m_data_d = fifo_rd_data;
        end else if (occ_q > OCC_W'(pop_c)) begin
            m_data_d = buf_q[rd_ptr_d];
        end

        m_valid_d = (occ_d != '0);
        busy_d    = (occ_d != '0) | inflight_d;

        if (flush) begin
            occ_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
            m_valid_d  = 1'b0;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            m_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            m_data_q   <= '0;
        end else begin
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            m_valid_q  <= m_valid_d;
            busy_q     <= busy_d;
            m_data_q   <= m_data_d;
        end
    end

    // Queue storage needs no reset; pointers and occupancy define validity.
    always_ff @(posedge rd_clk) begin
        if (capture_c && !flush && !rst) begin
            buf_q[wr_ptr_q] <= fifo_rd_data;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = busy_q;

`ifdef FIFO_RD_DRAIN_STATS_EN
    logic [15:0] pop_cnt_q, pop_cnt_d;

    // Flush leaves the counter alone; only reset clears it.
    always_comb begin
        pop_cnt_d = pop_cnt_q + 16'(pop_c);
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            pop_cnt_q <= '0;
        end else begin
            pop_cnt_q <= pop_cnt_d;
        end
    end

    assign pop_count = pop_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: behavioural FIFO source, scoreboard monitor on the output stream, directed scenarios.
module tb_fifo_rd_drain;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 2;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy;
`ifdef FIFO_RD_DRAIN_STATS_EN
    logic [15:0]   pop_count;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic          ren_s = 1'b0;

    fifo_rd_drain #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .enable      (enable),
        .flush       (flush),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy)
`ifdef FIFO_RD_DRAIN_STATS_EN
        ,
        .pop_count   (pop_count)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural FIFO: rd_data appears the cycle after rd_en; empty refreshes after stimulus updates.
    always @(negedge rd_clk) ren_s = fifo_rd_en;

    always @(posedge rd_clk) begin
        #1;
        if (ren_s) begin
            if (fq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL over_read: rd_en with empty FIFO @%0t", $time);
            end else begin
                fifo_rd_data = fq.pop_front();
            end
        end
        #2;
        fifo_empty = (fq.size() == 0);
    end

    // Scoreboard monitor: every accepted output word must match the next expected FIFO word.
    always @(negedge rd_clk) begin
        logic [DW-1:0] e;
        if (!rst && !flush && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got=%0h want=none @%0t", m_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(m_data), 32'(e));
            end
        end
    end

    task automatic cyc();
        @(posedge rd_clk);
        #2;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge rd_clk);
            if (!busy && !m_valid && !fifo_rd_en && fq.size() == 0) done = 1'b1;
            else cyc();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s: got=busy want=idle within %0d cycles", name, budget);
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] rd_pat7, v_pat7;
        logic [5:0] rd_pat6;

        // Reset state
        repeat (3) cyc();
        @(negedge rd_clk);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
`ifdef FIFO_RD_DRAIN_STATS_EN
        chk("rst_pop_count", 32'(pop_count), 32'h0);
`endif
        cyc();
        rst = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        cyc();

        // Single word
        push(8'hAA);
        @(negedge rd_clk);
        chk("t1_rd_en_c0", 32'(fifo_rd_en), 32'h1);
        chk("t1_valid_c0", 32'(m_valid), 32'h0);
        cyc(); @(negedge rd_clk);
        chk("t1_rd_en_c1", 32'(fifo_rd_en), 32'h0);
        chk("t1_valid_c1", 32'(m_valid), 32'h0);
        chk("t1_busy_c1", 32'(busy), 32'h1);
        cyc(); @(negedge rd_clk);
        chk("t1_valid_c2", 32'(m_valid), 32'h1);
        chk("t1_data_c2", 32'(m_data), 32'hAA);
        chk("t1_busy_c2", 32'(busy), 32'h1);
        cyc(); @(negedge rd_clk);
        chk("t1_valid_c3", 32'(m_valid), 32'h0);
        chk("t1_busy_c3", 32'(busy), 32'h0);
        cyc();

        // Streaming four words at full rate
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        rd_pat7 = '0;
        v_pat7  = '0;
        for (int k = 0; k < 7; k++) begin
            @(negedge rd_clk);
            rd_pat7 = {fifo_rd_en, rd_pat7[6:1]};
            v_pat7  = {m_valid, v_pat7[6:1]};
            cyc();
        end
        chk("t2_rd_en_pattern", 32'(rd_pat7), 32'h0F);
        chk("t2_valid_pattern", 32'(v_pat7), 32'h3C);
        wait_idle("t2_idle", 20);

        // Backpressure
        m_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        rd_pat6 = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge rd_clk);
            rd_pat6 = {fifo_rd_en, rd_pat6[5:1]};
            if (k == 3) chk("t3_hold_data_c3", 32'(m_data), 32'h11);
            if (k == 5) begin
                chk("t3_hold_data_c5", 32'(m_data), 32'h11);
                chk("t3_hold_valid_c5", 32'(m_valid), 32'h1);
            end
            cyc();
        end
        chk("t3_rd_en_pattern", 32'(rd_pat6), 32'h03);
        m_ready = 1'b1;
        wait_idle("t3_idle", 40);

        // Empty guard with toggling ready
        for (int k = 0; k < 8; k++) begin
            m_ready = ~m_ready;
            @(negedge rd_clk);
            chk("t4_rd_en", 32'(fifo_rd_en), 32'h0);
            chk("t4_valid", 32'(m_valid), 32'h0);
            chk("t4_busy", 32'(busy), 32'h0);
            cyc();
        end

        // Flush with one word queued and one in flight
        m_ready = 1'b0;
        push(8'h11); push(8'h5A);
        cyc(); cyc();
        flush = 1'b1;
        exp_q.delete();
        @(negedge rd_clk);
        chk("t5_rd_en_flush", 32'(fifo_rd_en), 32'h0);
        cyc();
        flush = 1'b0;
        @(negedge rd_clk);
        chk("t5_valid_after", 32'(m_valid), 32'h0);
        chk("t5_busy_after", 32'(busy), 32'h0);
        cyc();
        push(8'h22);
        m_ready = 1'b1;
        wait_idle("t5_idle", 20);

        // Reset during the CC transfer
        push(8'hAA); push(8'hBB); push(8'hCC);
        repeat (4) cyc();
        rst = 1'b1;
        exp_q.delete();
        @(negedge rd_clk);
        chk("t6_rd_en_in_rst", 32'(fifo_rd_en), 32'h0);
        cyc();
        push(8'hDD);
        @(negedge rd_clk);
        chk("t6_valid_rst", 32'(m_valid), 32'h0);
        chk("t6_data_rst", 32'(m_data), 32'h0);
        chk("t6_busy_rst", 32'(busy), 32'h0);
        chk("t6_rd_en_rst_nonempty", 32'(fifo_rd_en), 32'h0);
`ifdef FIFO_RD_DRAIN_STATS_EN
        chk("t6_pop_count_rst", 32'(pop_count), 32'h0);
`endif
        cyc();
        rst = 1'b0;
        push(8'hEE);
        wait_idle("t6_idle", 20);
`ifdef FIFO_RD_DRAIN_STATS_EN
        @(negedge rd_clk);
        chk("t6_pop_count_2", 32'(pop_count), 32'h2);
`endif

        chk("sb_leftover", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
